// File: rtl/plot_pkg.sv
// Shared defaults, state encoding and requester indices for the VGA pixel-port arbiter.
package plot_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int REQ_BG     = 0;
    localparam int REQ_SPRITE = 1;
    localparam int REQ_CLEAR  = 2;

    // Index increment modulo n, used for round-robin pointer updates.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          found
);

    // Scan from farthest to nearest so the closest-to-ptr requester is written last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                winner = PW'((int'(ptr) + k) % N);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the VGA pixel-write port; clips and
// registers the accepted pixel one cycle after ack.
module plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int X_W       = plot_pkg::X_W,
    parameter int Y_W       = plot_pkg::Y_W,
    parameter int COLOUR_W  = plot_pkg::COLOUR_W,
    parameter int SCREEN_W  = plot_pkg::SCREEN_W,
    parameter int SCREEN_H  = plot_pkg::SCREEN_H,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           ack,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         plot,
    output logic                         busy
);
    import plot_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t              state;
    logic [PW-1:0]       owner, ptr, pick_ptr, winner, grant, owner_inc, winner_inc;
    logic [CW-1:0]       count;
    logic                found, rel, hold, xfer, in_bounds;
    logic [X_W-1:0]      px;
    logic [Y_W-1:0]      py;
    logic [COLOUR_W-1:0] pc;

    assign owner_inc  = PW'(wrap_inc(int'(owner), NUM_REQ));
    assign winner_inc = PW'(wrap_inc(int'(winner), NUM_REQ));

    assign rel  = !req[owner] || (count == CW'(MAX_BURST));
    assign hold = (state == BURST) && !rel;

    // On release the scan starts just past the old owner, so it is considered last.
    assign pick_ptr = (state == BURST) ? owner_inc : ptr;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .found  (found)
    );

    assign grant = hold ? owner : winner;
    assign xfer  = !reset && en && (hold || found);
    assign ack   = xfer ? (NUM_REQ'(1) << grant) : '0;

    assign px = req_x[grant*X_W +: X_W];
    assign py = req_y[grant*Y_W +: Y_W];
    assign pc = req_colour[grant*COLOUR_W +: COLOUR_W];
    assign in_bounds = (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= '0;
            count      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else begin
            if (en) begin
                if (hold) begin
                    count <= count + 1'b1;
                end else begin
                    if (state == BURST)
                        ptr <= owner_inc;
                    if (found) begin
                        owner <= winner;
                        if (MAX_BURST == 1) begin
                            state <= IDLE;
                            ptr   <= winner_inc;
                            count <= '0;
                        end else begin
                            state <= BURST;
                            count <= CW'(1);
                        end
                    end else begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
            end
            // Clipped pixels still consume a grant but never raise plot.
            if (xfer) begin
                vga_x      <= px;
                vga_y      <= py;
                vga_colour <= pc;
                plot       <= in_bounds;
            end else begin
                plot <= 1'b0;
            end
        end
    end

    assign busy = (state == BURST) || plot;

endmodule
